// File: rtl/minesweeper_pkg.sv
// Shared button-action channel encodings and action_executor FSM state type.
package minesweeper_pkg;

  localparam logic [2:0] ACT_NONE   = 3'b000;
  localparam logic [2:0] ACT_REVEAL = 3'b001;
  localparam logic [2:0] ACT_FLAG   = 3'b010;
  localparam logic [2:0] ACT_RSVD   = 3'b011;
  localparam logic [2:0] ACT_U      = 3'b100;
  localparam logic [2:0] ACT_R      = 3'b101;
  localparam logic [2:0] ACT_D      = 3'b110;
  localparam logic [2:0] ACT_L      = 3'b111;

  localparam logic [1:0] CMD_REVEAL = 2'b01;
  localparam logic [1:0] CMD_FLAG   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_ACK      = 2'd2,
    ST_WAIT_CLR = 2'd3
  } state_t;

  function automatic logic is_move(input logic [2:0] code);
    return code[2];
  endfunction

  function automatic logic is_cmd(input logic [2:0] code);
    return (code == ACT_REVEAL) || (code == ACT_FLAG);
  endfunction

endpackage

// File: rtl/cursor_step.sv
// One cursor axis: next index after an optional +1/-1 step.
// Edge behaviour: wraps when CURSOR_WRAP_EN is defined, otherwise saturates.
module cursor_step #(
  parameter int SIZE = 8,
  parameter int W    = 3
) (
  input  logic [W-1:0] value,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] next
);

  // Last legal index; for non-power-of-two SIZE this is below 2^W-1.
  localparam logic [W-1:0] LAST = W'(SIZE - 1);

  always_comb begin
    next = value;
    if (inc) begin
`ifdef CURSOR_WRAP_EN
      if (value == LAST) next = '0;
      else               next = value + W'(1);
`else
      if (value != LAST) next = value + W'(1);
`endif
    end else if (dec) begin
`ifdef CURSOR_WRAP_EN
      if (value == '0) next = LAST;
      else             next = value - W'(1);
`else
      if (value != '0) next = value - W'(1);
`endif
    end
  end

endmodule

// File: rtl/action_executor.sv
// Consumes button action codes: moves the cursor or issues reveal/flag commands, then ACKs.
// Cursor edge behaviour selected by CURSOR_WRAP_EN (see cursor_step).
//
// state       | meaning
// ------------+-----------------------------------------------------
// ST_IDLE     | waiting for a non-zero action code
// ST_ISSUE    | cmd_valid high, waiting for cmd_ready
// ST_ACK      | action consumed, ack pulse being generated
// ST_WAIT_CLR | waiting for the encoder to clear its code to 000
module action_executor
  import minesweeper_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       action,
  output logic             ack,
  input  logic             game_over,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             cmd_valid,
  output logic [1:0]       cmd_op,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  input  logic             cmd_ready
);

  state_t           state, state_next;
  logic             ack_d;
  logic             valid_d;
  logic             accept;
  logic             latch_cmd;
  logic [ROW_W-1:0] row_next;
  logic [COL_W-1:0] col_next;

  assign accept = (state == ST_IDLE);

  cursor_step #(.SIZE(ROWS), .W(ROW_W)) u_row_step (
    .value (cursor_row),
    .inc   (accept && (action == ACT_D)),
    .dec   (accept && (action == ACT_U)),
    .next  (row_next)
  );

  cursor_step #(.SIZE(COLS), .W(COL_W)) u_col_step (
    .value (cursor_col),
    .inc   (accept && (action == ACT_R)),
    .dec   (accept && (action == ACT_L)),
    .next  (col_next)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (action != ACT_NONE) begin
          if (is_cmd(action) && !game_over) state_next = ST_ISSUE;
          else                              state_next = ST_ACK;
        end
      end
      ST_ISSUE:    if (cmd_ready) state_next = ST_ACK;
      ST_ACK:      state_next = ST_WAIT_CLR;
      ST_WAIT_CLR: if (action == ACT_NONE) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Moves/drops raise ack on the edge that enters ST_ACK. After a handshake the
  // pulse comes one edge later; in ST_ACK a still-low ack marks that path.
  assign ack_d     = (accept && (state_next == ST_ACK)) || ((state == ST_ACK) && !ack);
  assign valid_d   = (state_next == ST_ISSUE);
  assign latch_cmd = accept && (state_next == ST_ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ack        <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_op     <= 2'b00;
      cmd_row    <= '0;
      cmd_col    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
    end else begin
      state      <= state_next;
      ack        <= ack_d;
      cmd_valid  <= valid_d;
      cursor_row <= row_next;
      cursor_col <= col_next;
      if (latch_cmd) begin
        cmd_op  <= action[1:0];
        cmd_row <= cursor_row;
        cmd_col <= cursor_col;
      end
    end
  end

endmodule
